// File: rtl/reset_seq_pkg.sv
// Shared encodings for the board reset sequencer: FSM states and reset-cause codes.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      RUN      = 2'd1,
      DEB      = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_BTN = 2'b10;

endpackage

// File: rtl/reset_seq_sync2.sv
// Two-flop synchronizer; presets to 1 so an idle (released) input reads high out of reset.
module sync2 (
   input  logic clk,
   input  logic n_preset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge n_preset) begin
      if (!n_preset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_seq.sv
// Board reset sequencer: stretches power-on reset, debounces the reset button on
// press and release, drives n_reset_out from a flop and records what caused the last reset.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int HOLD_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int CNT_W           = 16
) (
   input  logic       clk_x2,
   input  logic       n_reset_in,
   input  logic       n_btn,
   output logic       n_reset_out,
   output logic       busy,
   output logic [1:0] cause
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
   logic             n_reset_out_d, busy_d;
   logic [1:0]       cause_d;
   logic             btn_s;

   sync2 u_btn_sync (
      .clk      (clk_x2),
      .n_preset (n_reset_in),
      .d        (n_btn),
      .q        (btn_s)
   );

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk_x2 or negedge n_reset_in) begin
      if (!n_reset_in) begin
         state       <= HOLD;
         cnt         <= '0;
         n_reset_out <= 1'b0;
         busy        <= 1'b1;
         cause       <= CAUSE_POR;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         n_reset_out <= n_reset_out_d;
         busy        <= busy_d;
         cause       <= cause_d;
      end
   end

   // In DEB and WAIT_REL, cnt holds the number of qualifying samples already seen,
   // so the current sample is the DEBOUNCE_CYCLES-th when cnt reaches DEB_LAST.
   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      n_reset_out_d = n_reset_out;
      cause_d       = cause;
      case (state)
         HOLD: begin
            if (cnt == HOLD_LAST) begin
               state_d       = RUN;
               cnt_d         = '0;
               n_reset_out_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RUN: begin
            if (!btn_s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d       = WAIT_REL;
                  cnt_d         = '0;
                  n_reset_out_d = 1'b0;
                  cause_d       = CAUSE_BTN;
               end else begin
                  state_d = DEB;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         DEB: begin
            if (btn_s) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt == DEB_LAST) begin
               state_d       = WAIT_REL;
               cnt_d         = '0;
               n_reset_out_d = 1'b0;
               cause_d       = CAUSE_BTN;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_REL: begin
            if (!btn_s) begin
               cnt_d = '0;
            end else if (cnt == DEB_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
      endcase
      busy_d = (state_d != RUN);
   end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: expected n_reset_out transitions are queued with the
// stimulus and matched as the DUT produces them; busy/cause checked at chosen points.
module tb_reset_seq;

   localparam int HOLD_N = 4;
   localparam int DEB_N  = 8;

   logic       clk_x2     = 1'b0;
   logic       clk_run    = 1'b1;
   logic       n_reset_in = 1'b1;
   logic       n_btn      = 1'b1;
   logic       n_reset_out;
   logic       busy;
   logic [1:0] cause;

   typedef struct {
      int   edge_no;
      logic level;
   } exp_t;

   exp_t exp_q[$];
   int   edge_cnt = 0;
   int   checks   = 0;
   int   errors   = 0;
   logic prev_out = 1'b0;

   reset_seq #(
      .HOLD_CYCLES     (HOLD_N),
      .DEBOUNCE_CYCLES (DEB_N),
      .CNT_W           (16)
   ) dut (
      .clk_x2      (clk_x2),
      .n_reset_in  (n_reset_in),
      .n_btn       (n_btn),
      .n_reset_out (n_reset_out),
      .busy        (busy),
      .cause       (cause)
   );

   always #5 if (clk_run) clk_x2 = ~clk_x2;

   task apply_stimulus(input logic rst_v, input logic btn_v);
      n_reset_in = rst_v;
      n_btn      = btn_v;
   endtask

   task expect_edge(input int offset, input logic level);
      exp_t ev;
      ev.edge_no = edge_cnt + offset;
      ev.level   = level;
      exp_q.push_back(ev);
   endtask

   task check_output(input string tag, input logic [1:0] observed, input logic [1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (edge %0d)", tag, observed, expected, edge_cnt);
      end
   endtask

   // Scoreboard side: flag an expected transition whose edge has passed, then match any change.
   task observe();
      exp_t ev;
      if (exp_q.size() > 0) begin
         checks++;
         assert (exp_q[0].edge_no >= edge_cnt) else begin
            errors++;
            ev = exp_q.pop_front();
            $error("FAIL n_reset_out_missed: still %b at edge %0d, expected %b at edge %0d",
                   n_reset_out, edge_cnt, ev.level, ev.edge_no);
         end
      end
      if (n_reset_out !== prev_out) begin
         checks++;
         if (exp_q.size() == 0) begin
            ev.edge_no = -1;
            ev.level   = prev_out;
         end else begin
            ev = exp_q.pop_front();
         end
         assert (edge_cnt === ev.edge_no && n_reset_out === ev.level) else begin
            errors++;
            $error("FAIL n_reset_out_edge: observed %b at edge %0d, expected %b at edge %0d",
                   n_reset_out, edge_cnt, ev.level, ev.edge_no);
         end
         prev_out = n_reset_out;
      end
   endtask

   task tick(input int n);
      repeat (n) begin
         @(posedge clk_x2);
         #1;
         edge_cnt++;
         observe();
      end
   endtask

   initial begin
      // 1: power-on reset stretched to HOLD_N edges after release
      #1 apply_stimulus(1'b0, 1'b1);
      tick(3);
      check_output("por_n_reset_out", {1'b0, n_reset_out}, 2'b00);
      check_output("por_busy", {1'b0, busy}, 2'b01);
      check_output("por_cause", cause, 2'b01);
      apply_stimulus(1'b1, 1'b1);
      expect_edge(HOLD_N, 1'b1);
      for (int k = 1; k <= HOLD_N; k++) begin
         tick(1);
         check_output("hold_busy", {1'b0, busy}, (k < HOLD_N) ? 2'b01 : 2'b00);
      end
      check_output("hold_done_out", {1'b0, n_reset_out}, 2'b01);
      check_output("hold_done_cause", cause, 2'b01);

      // 2: 5-cycle glitch enters DEB briefly but never resets
      apply_stimulus(1'b1, 1'b0);
      tick(5);
      apply_stimulus(1'b1, 1'b1);
      for (int k = 6; k <= 12; k++) begin
         tick(1);
         check_output("glitch_busy", {1'b0, busy}, (k >= 3 && k <= 7) ? 2'b01 : 2'b00);
      end
      check_output("glitch_cause", cause, 2'b01);

      // 3: clean 20-cycle press
      apply_stimulus(1'b1, 1'b0);
      expect_edge(2 + DEB_N, 1'b0);
      tick(9);
      check_output("press_deb_busy", {1'b0, busy}, 2'b01);
      check_output("press_deb_cause", cause, 2'b01);
      tick(11);
      check_output("press_cause", cause, 2'b10);
      check_output("press_busy", {1'b0, busy}, 2'b01);
      apply_stimulus(1'b1, 1'b1);
      expect_edge(2 + DEB_N + HOLD_N, 1'b1);
      tick(13);
      check_output("release_hold_busy", {1'b0, busy}, 2'b01);
      tick(3);
      check_output("release_busy", {1'b0, busy}, 2'b00);
      check_output("release_out", {1'b0, n_reset_out}, 2'b01);

      // 4: bouncy release restarts the release count
      apply_stimulus(1'b1, 1'b0);
      expect_edge(2 + DEB_N, 1'b0);
      tick(12);
      apply_stimulus(1'b1, 1'b1);
      tick(3);
      apply_stimulus(1'b1, 1'b0);
      tick(1);
      apply_stimulus(1'b1, 1'b1);
      expect_edge(2 + DEB_N + HOLD_N, 1'b1);
      tick(16);
      check_output("bounce_cause", cause, 2'b10);
      check_output("bounce_busy", {1'b0, busy}, 2'b00);

      // 5: asynchronous reset mid-DEB with the clock stopped
      apply_stimulus(1'b1, 1'b0);
      tick(5);
      check_output("mid_deb_busy", {1'b0, busy}, 2'b01);
      @(negedge clk_x2);
      #1 clk_run = 1'b0;
      #30 apply_stimulus(1'b0, 1'b0);
      expect_edge(0, 1'b0);
      #2 observe();
      check_output("async_out", {1'b0, n_reset_out}, 2'b00);
      check_output("async_cause", cause, 2'b01);
      check_output("async_busy", {1'b0, busy}, 2'b01);
      #20 apply_stimulus(1'b1, 1'b1);
      expect_edge(HOLD_N, 1'b1);
      #20 clk_run = 1'b1;
      tick(6);
      check_output("async_after_busy", {1'b0, busy}, 2'b00);
      check_output("async_after_cause", cause, 2'b01);

      // 6: button held across reset release is only seen once RUN is reached
      apply_stimulus(1'b0, 1'b1);
      expect_edge(0, 1'b0);
      #1 observe();
      apply_stimulus(1'b0, 1'b0);
      tick(3);
      check_output("held_rst_cause", cause, 2'b01);
      apply_stimulus(1'b1, 1'b0);
      expect_edge(HOLD_N, 1'b1);
      expect_edge(HOLD_N + DEB_N, 1'b0);
      tick(14);
      check_output("held_cause", cause, 2'b10);
      check_output("held_busy", {1'b0, busy}, 2'b01);
      apply_stimulus(1'b1, 1'b1);
      expect_edge(2 + DEB_N + HOLD_N, 1'b1);
      tick(16);
      check_output("held_end_busy", {1'b0, busy}, 2'b00);
      check_output("held_end_out", {1'b0, n_reset_out}, 2'b01);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d pending transitions, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
